// File: rtl/hoff_stream_scheduler.sv
// Round-robin arbiter that lends the shared Huffman bit-packer to one encoder lane
// per complete stream and holds the next grant until the stream's final word is consumed.
module hoff_stream_scheduler #(
   parameter int unsigned N_LANES = 4,
   parameter int unsigned LANE_W  = 2,
   parameter int unsigned WCNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_LANES-1:0]      lane_valid,
   input  logic [32*N_LANES-1:0]   lane_data,
   input  logic [5*N_LANES-1:0]    lane_nbits,
   input  logic [N_LANES-1:0]      lane_last,
   output logic [N_LANES-1:0]      lane_ready,
   output logic [31:0]             H_final_data,
   output logic [4:0]              total_valid_datas,
   output logic                    FIFO_in_last,
   output logic                    H_data_valid,
   input  logic                    FIFO_FULL_NEED_STALL,
   input  logic                    collect_bits_valid,
   input  logic                    deal_FF_done,
   input  logic                    to_FF_last,
   output logic                    busy,
   output logic [LANE_W-1:0]       grant_id,
   output logic                    stream_done,
   output logic [WCNT_W-1:0]       stream_words
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned NB_W   = 5;
   localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [LANE_W-1:0]   rr_ptr, rr_nxt;
   logic [LANE_W-1:0]   grant_nxt;
   logic [WCNT_W-1:0]   wcnt, wcnt_nxt;

   logic [LANE_W-1:0]   arb_idx;
   logic                arb_found;
   logic [DATA_W-1:0]   g_data;
   logic [NB_W-1:0]     g_nbits;
   logic                g_valid;
   logic                g_last;
   logic                word_take;
   logic                beat_acc;

   assign word_take = collect_bits_valid & deal_FF_done;
   assign beat_acc  = g_valid & ~FIFO_FULL_NEED_STALL;
   assign busy      = (state != S_IDLE);

   // Round-robin search starting at rr_ptr, wrapping modulo N_LANES
   always_comb begin
      int unsigned idx;
      arb_found = 1'b0;
      arb_idx   = '0;
      idx       = 0;
      for (int unsigned k = 0; k < N_LANES; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= N_LANES) idx = idx - N_LANES;
         if (!arb_found && lane_valid[LANE_W'(idx)]) begin
            arb_found = 1'b1;
            arb_idx   = LANE_W'(idx);
         end
      end
   end

   // Granted lane's payload, selected with constant slices
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      g_nbits = '0;
      for (int unsigned i = 0; i < N_LANES; i++) begin
         if (grant_id == LANE_W'(i)) begin
            g_valid = lane_valid[i];
            g_last  = lane_last[i];
            g_data  = lane_data[DATA_W*i +: DATA_W];
            g_nbits = lane_nbits[NB_W*i +: NB_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         wcnt     <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         grant_id <= grant_nxt;
         wcnt     <= wcnt_nxt;
      end
   end

   // Next-state and handshake outputs; payload is a zero-latency pass-through in STREAM
   always_comb begin
      state_nxt         = state;
      rr_nxt            = rr_ptr;
      grant_nxt         = grant_id;
      wcnt_nxt          = wcnt;
      lane_ready        = '0;
      H_data_valid      = 1'b0;
      H_final_data      = '0;
      total_valid_datas = '0;
      FIFO_in_last      = 1'b0;
      stream_done       = 1'b0;
      stream_words      = '0;

      case (state)
         S_IDLE: begin
            if (arb_found) begin
               grant_nxt = arb_idx;
               wcnt_nxt  = '0;
               state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
               lane_ready[i] = (grant_id == LANE_W'(i)) & ~FIFO_FULL_NEED_STALL;
            end
            H_data_valid      = beat_acc;
            H_final_data      = g_data;
            total_valid_datas = g_nbits;
            FIFO_in_last      = g_last;
            if (word_take && (wcnt != WCNT_MAX)) wcnt_nxt = wcnt + WCNT_W'(1);
            if (beat_acc && g_last) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (word_take && (wcnt != WCNT_MAX)) wcnt_nxt = wcnt + WCNT_W'(1);
            if (word_take && to_FF_last) state_nxt = S_DONE;
         end
         S_DONE: begin
            stream_done  = 1'b1;
            stream_words = wcnt;
            rr_nxt       = (grant_id == LANE_W'(N_LANES - 1)) ? '0 : grant_id + LANE_W'(1);
            state_nxt    = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
